// File: rtl/mandelbrot_core.sv
// mandelbrot_core
//   Fixed-point Mandelbrot escape-time engine for a single point c = re + i*im.
//   Iterates z(n+1) = z(n)^2 + c from z(0) = 0.
//   The result is the first n >= 1 with |z(n)|^2 > 4, saturated at ITER_MAX.
//   Each iteration takes two cycles: MUL registers the squares, and UPD decides
//   or advances. With result k, io_done pulses 2(k+1)+1 cycles after the start edge.
//
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous active-low reset
//   io_start        start request, honoured only in IDLE
//   io_re, io_im    signed Q(FP_INT).(FRAC) point, captured on the start edge
//   io_iter         escape count, valid from io_done until the next start
//   io_calculating  high while an iteration is in progress
//   io_done         one-cycle pulse when io_iter is final
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for io_start; latches c and clears z, n
// MUL    | registers x^2, y^2 and x*y of z(n)
// UPD    | escape / saturation decision, otherwise z <- z^2 + c, n++
// DONE   | result final; io_done registered high, io_calculating cleared
module mandelbrot_core #(
    parameter  int FP_WIDTH = 25,
    parameter  int FP_INT   = 4,
    parameter  int ITER_MAX = 255,
    localparam int ITERW    = $clog2(ITER_MAX + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_start,
    input  logic signed [FP_WIDTH-1:0] io_re,
    input  logic signed [FP_WIDTH-1:0] io_im,
    output logic        [ITERW-1:0]    io_iter,
    output logic                       io_calculating,
    output logic                       io_done
);

    localparam int FRAC = FP_WIDTH - FP_INT;
    localparam int ZW   = FP_WIDTH + 2;   // z register width
    localparam int PW   = 2 * ZW;         // full product width
    localparam int SQW  = PW - FRAC;      // product after the >>> FRAC shift
    localparam int SUMW = SQW + 1;        // headroom for sums of two squares

    localparam logic signed [SUMW-1:0] FOUR  = SUMW'(4) << FRAC;
    localparam logic        [ITERW-1:0] N_MAX = ITERW'(ITER_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_UPD,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic signed [ZW-1:0]    x, y, cre, cim;
    logic signed [SQW-1:0]   xx, yy, xy;
    logic        [ITERW-1:0] n;

    logic signed [PW-1:0]    prod_xx, prod_yy, prod_xy;
    logic signed [SUMW-1:0]  mag2, x_upd, y_upd;
    logic                    escape, at_max;
    logic                    unused_bits;

    // Keeping the upper product bits and dropping the low FRAC bits gives an
    // arithmetic shift right, i.e. truncation toward minus infinity.
    always_comb begin
        prod_xx = PW'(x) * PW'(x);
        prod_yy = PW'(y) * PW'(y);
        prod_xy = PW'(x) * PW'(y);
    end

    // z stays within about +/-12 whenever an update happens. So the narrowing
    // of x_upd/y_upd back to ZW bits never drops significant bits.
    always_comb begin
        mag2   = SUMW'(xx) + SUMW'(yy);
        x_upd  = SUMW'(xx) - SUMW'(yy) + SUMW'(cre);
        y_upd  = $signed({xy, 1'b0}) + SUMW'(cim);
        escape = (n != '0) && (mag2 > FOUR);
        at_max = (n == N_MAX);
    end

    assign unused_bits = ^{prod_xx[FRAC-1:0], prod_yy[FRAC-1:0], prod_xy[FRAC-1:0],
                           x_upd[SUMW-1:ZW], y_upd[SUMW-1:ZW]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (io_start) state_next = S_MUL;
            S_MUL:   state_next = S_UPD;
            S_UPD:   state_next = (escape || at_max) ? S_DONE : S_MUL;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x              <= '0;
            y              <= '0;
            cre            <= '0;
            cim            <= '0;
            xx             <= '0;
            yy             <= '0;
            xy             <= '0;
            n              <= '0;
            io_iter        <= '0;
            io_calculating <= 1'b0;
            io_done        <= 1'b0;
        end else begin
            io_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (io_start) begin
                        cre            <= {{2{io_re[FP_WIDTH-1]}}, io_re};
                        cim            <= {{2{io_im[FP_WIDTH-1]}}, io_im};
                        x              <= '0;
                        y              <= '0;
                        n              <= '0;
                        io_calculating <= 1'b1;
                    end
                end
                S_MUL: begin
                    xx <= prod_xx[PW-1:FRAC];
                    yy <= prod_yy[PW-1:FRAC];
                    xy <= prod_xy[PW-1:FRAC];
                end
                S_UPD: begin
                    if (escape) begin
                        io_iter <= n;
                    end else if (at_max) begin
                        io_iter <= N_MAX;
                    end else begin
                        x <= x_upd[ZW-1:0];
                        y <= y_upd[ZW-1:0];
                        n <= n + ITERW'(1);
                    end
                end
                S_DONE: begin
                    io_done        <= 1'b1;
                    io_calculating <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_core.sv
module tb_mandelbrot_core;

    localparam int FP_WIDTH = 25;
    localparam int FP_INT   = 4;
    localparam int ITER_MAX = 255;
    localparam int ITERW    = $clog2(ITER_MAX + 1);
    localparam int FRAC     = FP_WIDTH - FP_INT;
    localparam int ONE      = 1 << FRAC;

    logic                       clock;
    logic                       reset;
    logic                       io_start;
    logic signed [FP_WIDTH-1:0] io_re;
    logic signed [FP_WIDTH-1:0] io_im;
    logic        [ITERW-1:0]    io_iter;
    logic                       io_calculating;
    logic                       io_done;

    int n_checks = 0;
    int n_pass   = 0;

    mandelbrot_core #(
        .FP_WIDTH(FP_WIDTH),
        .FP_INT  (FP_INT),
        .ITER_MAX(ITER_MAX)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_start      (io_start),
        .io_re         (io_re),
        .io_im         (io_im),
        .io_iter       (io_iter),
        .io_calculating(io_calculating),
        .io_done       (io_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Escape-time reference: plain integer arithmetic on the fixed-point values,
    // with each product floored by 2^FRAC.
    function automatic int model_iter(input longint re, input longint im);
        longint x = 0, y = 0, xx, yy, xy;
        for (int k = 1; k <= ITER_MAX; k++) begin
            xx = (x * x) >>> FRAC;
            yy = (y * y) >>> FRAC;
            xy = (x * y) >>> FRAC;
            x  = xx - yy + re;
            y  = 2 * xy + im;
            if (((x * x) >>> FRAC) + ((y * y) >>> FRAC) > (longint'(4) <<< FRAC))
                return k;
        end
        return ITER_MAX;
    endfunction

    // Call at #1 after a clock edge. Returns at #1 after the edge where io_done is seen.
    task automatic run_point(input string tag, input logic signed [FP_WIDTH-1:0] re,
                             input logic signed [FP_WIDTH-1:0] im, input int exp_iter,
                             input bit scramble, input int poke);
        int  m = 0;
        bit  seen = 0;
        int  calc_low = 0;
        io_start = 1'b1;
        io_re    = re;
        io_im    = im;
        @(posedge clock); #1;
        io_start = 1'b0;
        check({tag, "_done_low_at_start"}, io_done, 0);
        check({tag, "_calc_at_start"}, io_calculating, 1);
        while (!seen && m < 600) begin
            @(posedge clock); #1;
            m++;
            if (scramble || m == poke) begin
                io_re = FP_WIDTH'($urandom);
                io_im = FP_WIDTH'($urandom);
            end
            io_start = (m == poke);
            if (io_done) seen = 1;
            else if (!io_calculating) calc_low++;
        end
        io_start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_iter"}, io_iter, exp_iter);
        check({tag, "_latency"}, m, 2 * exp_iter + 3);
        check({tag, "_calc_gaps"}, calc_low, 0);
        check({tag, "_calc_low_at_done"}, io_calculating, 0);
    endtask

    initial begin
        int dones;
        int exp_i;
        logic signed [FP_WIDTH-1:0] r, i;

        reset    = 1'b0;
        io_start = 1'b0;
        io_re    = '0;
        io_im    = '0;
        #2;
        check("rst_iter", io_iter, 0);
        check("rst_calc", io_calculating, 0);
        check("rst_done", io_done, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        // c = 3.0: escapes on the first iterate
        run_point("c3", FP_WIDTH'(3 * ONE), '0, 1, 0, 0);

        // reset in the middle of a long run
        io_start = 1'b1; io_re = '0; io_im = '0;
        @(posedge clock); #1;
        io_start = 1'b0;
        repeat (20) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("midrst_iter", io_iter, 0);
        check("midrst_calc", io_calculating, 0);
        check("midrst_done", io_done, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        dones = 0;
        repeat (530) begin
            @(posedge clock); #1;
            if (io_done) dones++;
        end
        check("midrst_no_done", dones, 0);
        check("midrst_calc_idle", io_calculating, 0);
        run_point("after_rst", FP_WIDTH'(3 * ONE), '0, 1, 0, 0);

        // escape-boundary points on the real axis
        run_point("c2",  FP_WIDTH'(2 * ONE), '0, 2, 0, 0);
        run_point("c1",  FP_WIDTH'(ONE),     '0, 3, 0, 0);
        run_point("c05", FP_WIDTH'(ONE / 2), '0, 5, 0, 0);

        // bounded orbits saturate at ITER_MAX
        run_point("c0",  '0,                   '0,              ITER_MAX, 0, 0);
        run_point("cm2", FP_WIDTH'(-2 * ONE),  '0,              ITER_MAX, 0, 0);
        run_point("ci",  '0,                   FP_WIDTH'(ONE),  ITER_MAX, 0, 0);

        // start pulse while busy is ignored; then start right after DONE
        run_point("poke", FP_WIDTH'(ONE / 2), '0, 5, 0, 3);
        run_point("b2b",  FP_WIDTH'(3 * ONE), '0, 1, 0, 0);

        // inputs scrambled after capture; result must be held afterwards
        run_point("scr", FP_WIDTH'(ONE), '0, 3, 1, 0);
        repeat (6) @(posedge clock);
        #1;
        check("hold_iter", io_iter, 3);
        check("hold_done", io_done, 0);
        check("hold_calc", io_calculating, 0);

        // random points, mostly around the set plus a few over the full range
        for (int t = 0; t < 16; t++) begin
            if (t < 12) begin
                r = FP_WIDTH'(int'($urandom_range(0, 5 * ONE)) - 5 * ONE / 2);
                i = FP_WIDTH'(int'($urandom_range(0, 3 * ONE)) - 3 * ONE / 2);
            end else begin
                r = FP_WIDTH'($urandom);
                i = FP_WIDTH'($urandom);
            end
            exp_i = model_iter(longint'(r), longint'(i));
            run_point($sformatf("rnd%0d", t), r, i, exp_i, t[0], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mandelbrot_core.md
Name: mandelbrot_core

Overview:
Iterative fixed-point Mandelbrot escape-time engine. For one point c = re + i·im it iterates z(n+1) = z(n)² + c from z(0) = 0 and reports the escape iteration count. It is instantiated several times per pixel by the renderer for supersampling, with all instances started together. The renderer maps the count to a colour index and treats ITER_MAX as "inside the set".

Parameters:
FP_WIDTH, 25, total signed fixed-point width (integer + fractional bits); FRAC = FP_WIDTH − FP_INT.
FP_INT, 4, integer bits including sign (default format is Q4.21, range ±8).
ITER_MAX, 255, maximum iteration count; ITERW = clog2(ITER_MAX+1).

Ports:
clock  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-low reset.
io_start  in  1  start request; sampled only in IDLE.
io_re  in  FP_WIDTH signed  real part of c; sampled on the start edge.
io_im  in  FP_WIDTH signed  imaginary part of c; sampled on the start edge.
io_iter  out  ITERW  escape count; held until the next start.
io_calculating  out  1  high while an iteration is in progress.
io_done  out  1  one-cycle pulse when io_iter is final.

Behaviour:
- Reset (reset = 0, asynchronous): state goes to IDLE; io_iter, io_calculating, io_done, the internal z, c and n registers all clear to 0. Reset mid-calculation aborts the calculation and emits no done pulse.
- Inputs are registered: io_re and io_im are captured when io_start is sampled high in IDLE, and may change freely afterwards.
- io_start outside IDLE is ignored.
- State machine: IDLE → MUL → UPD → (MUL | DONE) → IDLE.
- IDLE: on io_start, latch c, set z = 0, n = 0, io_calculating = 1, go to MUL.
- MUL: register x², y² and x·y of z(n). Use full-precision products, arithmetic-shifted right by FRAC (truncation toward −∞).
- UPD, with priority in this order:
  - if n > 0 and x² + y² > 4.0 (strict), set io_iter = n and go to DONE;
  - else if n == ITER_MAX, set io_iter = ITER_MAX and go to DONE;
  - else set x ← x² − y² + re, y ← 2·x·y + im, n ← n + 1, and go to MUL.
- DONE: io_done = 1 for exactly this cycle, io_calculating = 0, then return to IDLE. A new io_start may be accepted in the cycle after DONE.
- Result definition: io_iter = min(e, ITER_MAX), where e is the smallest n ≥ 1 with |z(n)|² > 4.
- Latency: with result k, io_done is high 2(k+1)+1 cycles after the start edge. For k = 1 that is 5 cycles; for ITER_MAX it is 513.
- Width rules:
  - Internal z registers are FP_WIDTH+2 bits.
  - The squares sum has enough headroom that no wrap occurs for any legal c.
  - The comparison constant 4.0 is 4 << FRAC.
  - c is sign-extended into the internal width.
- io_iter is valid only from io_done onward; it is held until the next accepted start.

Test Plan:
1. Reset asserted while calculating (start c = 0, then pull reset low mid-run) → all outputs are 0 immediately; no io_done follows; the next start after reset release works normally.
2. c = 3.0 + 0i → io_iter = 1; io_done pulses 5 cycles after start; io_calculating is high for the intervening cycles.
3. c = 2.0 + 0i (|z1|² = 4, not > 4) → io_iter = 2. c = 1.0 + 0i → io_iter = 3. c = 0.5 + 0i → io_iter = 5.
4. c = 0, c = −2.0 + 0i, c = 0 + 1.0i (bounded cycle) → io_iter = 255; io_done pulses 513 cycles after start.
5. Pulse io_start again while calculating, with different re/im values → the pulse is ignored and the first result is unchanged. Start immediately after DONE with c = 3.0 → accepted and returns 1.
6. Change io_re and io_im every cycle after the start edge → the result matches the values captured at start. io_iter holds its value after io_done until the next start.
